spi_sram_master_seq: RTL

Single-clock SPI SRAM master that turns byte-wide read/write requests from the CPU-side cache into serial 23LC-style SPI transactions (0x03 READ, 0x02 WRITE, 24-bit address) on `cs_n`/`mosi`/`miso`. It sits between the cache and the external SPI SRAM (the `spi_sram_slave` model in simulation). The SPI clock is the system clock itself, so `clk` feeds the SRAM directly and is never gated. Sequential same-direction requests offered back-to-back are streamed without deasserting `cs_n`.

---
 rtl/spi_sram_pkg.sv | 32 +++
 rtl/spi_shift_reg.sv | 38 +++
 rtl/spi_sram_master.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI SRAM master: command bytes, frame geometry,
// bit-counter milestones and the sequencer state encoding.
package spi_sram_pkg;

  localparam int SPI_ADDR_W  = 24;
  localparam int SPI_FRAME_W = 40;
  localparam int SPI_CNT_W   = 6;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  // Bit-counter values: a frame counts 39 down to 0 across CMD, ADDR and DATA.
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_FRAME     = 6'd39;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_CMD_LAST  = 6'd32;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_ADDR_LAST = 6'd8;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_BYTE      = 6'd7;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_LAST      = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DLY,
    ST_DATA,
    ST_GAP
  } spi_state_t;

  function automatic logic [7:0] spi_cmd(input logic wr);
    return wr ? SPI_CMD_WRITE : SPI_CMD_READ;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// 40-bit parallel-load shift register with serial in/out and a down-counting
// bit counter; load takes priority over shift.
module spi_shift_reg
  import spi_sram_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [SPI_FRAME_W-1:0] i_load_data,
  input  logic [SPI_CNT_W-1:0]   i_load_cnt,
  input  logic                   i_shift,
  input  logic                   i_sin,
  output logic                   o_sout,
  output logic [6:0]             o_low7,
  output logic [SPI_CNT_W-1:0]   o_cnt
);

  logic [SPI_FRAME_W-1:0] r_data;
  logic [SPI_CNT_W-1:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= i_load_cnt;
    end else if (i_shift) begin
      r_data <= {r_data[SPI_FRAME_W-2:0], i_sin};
      r_cnt  <= r_cnt - SPI_CNT_W'(1);
    end
  end

  assign o_sout = r_data[SPI_FRAME_W-1];
  assign o_low7 = r_data[6:0];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/spi_sram_master.sv
// SPI SRAM master: accepts byte read/write requests and runs 23LC-style
// READ/WRITE frames, streaming sequential same-direction requests.
module spi_sram_master_seq
  import spi_sram_pkg::*;
#(
  parameter int CS_GAP     = 1,
  parameter int MISO_DELAY = 0
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso,
  output spi_state_t            dbg_state
);

  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] GAP_RELOAD = WAIT_W'(CS_GAP - 1);
  localparam logic [WAIT_W-1:0] DLY_RELOAD = (MISO_DELAY > 0) ? WAIT_W'(MISO_DELAY - 1) : '0;

  spi_state_t r_state, w_next;

  logic [SPI_ADDR_W-1:0]  r_cur_addr;
  logic                   r_cur_wr;
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_rsp_valid;
  logic [7:0]             r_rsp_rdata;

  logic                   w_accept;
  logic                   w_seq_match;
  logic                   w_last_data;
  logic                   w_sr_load;
  logic                   w_sr_shift;
  logic                   w_sr_sout;
  logic [SPI_FRAME_W-1:0] w_sr_load_data;
  logic [SPI_CNT_W-1:0]   w_sr_load_cnt;
  logic [SPI_CNT_W-1:0]   w_sr_cnt;
  logic [6:0]             w_sr_low7;

  spi_shift_reg u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_sr_load),
    .i_load_data(w_sr_load_data),
    .i_load_cnt (w_sr_load_cnt),
    .i_shift    (w_sr_shift),
    .i_sin      (miso),
    .o_sout     (w_sr_sout),
    .o_low7     (w_sr_low7),
    .o_cnt      (w_sr_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_CMD;
      ST_CMD:  if (w_sr_cnt == SPI_CNT_CMD_LAST) w_next = ST_ADDR;
      ST_ADDR: if (w_sr_cnt == SPI_CNT_ADDR_LAST)
                 w_next = (!r_cur_wr && MISO_DELAY > 0) ? ST_DLY : ST_DATA;
      ST_DLY:  if (r_wait == '0) w_next = ST_DATA;
      ST_DATA: if (w_last_data) w_next = w_accept ? ST_DATA : ST_GAP;
      ST_GAP:  if (r_wait == '0) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake: a request transfers on any edge where req_valid && req_ready.
  // req_ready is high in IDLE, and on the last DATA cycle only for a request
  // that continues the burst (same direction, next address), so a transfer
  // always means the request has been taken.
  always_comb begin
    w_seq_match    = (req_wr == r_cur_wr) && (req_addr == r_cur_addr + 24'd1);
    w_last_data    = (r_state == ST_DATA) && (w_sr_cnt == SPI_CNT_LAST);
    req_ready      = !rst && ((r_state == ST_IDLE) || (w_last_data && w_seq_match));
    w_accept       = req_valid && req_ready;
    cs_n           = (r_state == ST_IDLE) || (r_state == ST_GAP);
    mosi           = 1'b0;
    if ((r_state == ST_CMD) || (r_state == ST_ADDR) || ((r_state == ST_DATA) && r_cur_wr))
      mosi = w_sr_sout;
    w_sr_load      = w_accept;
    w_sr_load_data = (r_state == ST_IDLE) ? {spi_cmd(req_wr), req_addr, req_wdata}
                                          : {req_wdata, 32'h0};
    w_sr_load_cnt  = (r_state == ST_IDLE) ? SPI_CNT_FRAME : SPI_CNT_BYTE;
    w_sr_shift     = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_cur_wr    <= 1'b0;
      r_wait      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      // Bit 0 is on miso during the last DATA cycle, so it joins the byte here.
      if (w_last_data && !r_cur_wr) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= {w_sr_low7, miso};
      end
      if (w_accept) begin
        r_cur_addr <= req_addr;
        r_cur_wr   <= req_wr;
      end
      if (r_state != w_next && w_next == ST_DLY)      r_wait <= DLY_RELOAD;
      else if (r_state != w_next && w_next == ST_GAP) r_wait <= GAP_RELOAD;
      else if (r_wait != '0)                          r_wait <= r_wait - WAIT_W'(1);
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

endmodule
